// File: rtl/mult_inv_div_seq.sv
// mult_inv_div_seq: iterative restoring unsigned divider, one quotient bit per clock, registered in and out.
module mult_inv_div_seq #(
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [A_WIDTH-1:0] A,
    input  logic [B_WIDTH-1:0] B,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [A_WIDTH-1:0] Q,
    output logic [B_WIDTH-1:0] R,
    output logic               DZ
);
    localparam int CW = $clog2(A_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_n;
    logic [A_WIDTH-1:0] dvd;
    logic [B_WIDTH-1:0] dvs;
    logic [B_WIDTH-1:0] rem, rem_n;
    logic [B_WIDTH:0]   trial;
    logic               ge;
    logic [CW-1:0]      cnt;

    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == DONE);

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    always_comb begin
        trial   = {rem, dvd[A_WIDTH-1]};
        ge      = trial >= {1'b0, dvs};
        rem_n   = B_WIDTH'(ge ? trial - {1'b0, dvs} : trial);
        state_n = (state == IDLE) ? (IN_VALID ? ((B == '0) ? DONE : BUSY) : IDLE) :
                  (state == BUSY) ? ((cnt == CW'(1)) ? DONE : BUSY) :
                  (OUT_READY ? IDLE : DONE);
    end

    always_ff @(posedge CLK) state <= RST ? IDLE : state_n;

    always_ff @(posedge CLK) begin
        if (RST) begin
            dvd <= '0;
            dvs <= '0;
            rem <= '0;
            cnt <= '0;
            Q   <= '0;
            R   <= '0;
            DZ  <= 1'b0;
        end else if (state == IDLE && IN_VALID) begin
            dvd <= A;
            dvs <= B;
            rem <= '0;
            cnt <= (B == '0) ? '0 : CW'(A_WIDTH);
            if (B == '0) begin
                Q  <= '1;
                R  <= A[B_WIDTH-1:0];
                DZ <= 1'b1;
            end
        end else if (state == BUSY) begin
            dvd <= {dvd[A_WIDTH-2:0], ge};
            rem <= rem_n;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                Q  <= {dvd[A_WIDTH-2:0], ge};
                R  <= rem_n;
                DZ <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_inv_div_seq.sv
// tb_mult_inv_div_seq: directed and random checks of the divider against an arithmetic model.
module tb_mult_inv_div_seq;
    localparam int AW = 16;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst, iv, ir, ov, ordy, dz;
    logic [AW-1:0] a, q;
    logic [BW-1:0] b, r;
    logic          iv8, ir8, ov8, ordy8, dz8;
    logic [7:0]    a8, b8, q8, r8;

    logic [AW-1:0] exp_q;
    logic [BW-1:0] exp_r;
    logic          exp_dz;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    mult_inv_div_seq u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(iv), .IN_READY(ir), .A(a), .B(b),
        .OUT_VALID(ov), .OUT_READY(ordy), .Q(q), .R(r), .DZ(dz)
    );

    mult_inv_div_seq #(.A_WIDTH(8), .B_WIDTH(8)) u_dut8 (
        .CLK(clk), .RST(rst), .IN_VALID(iv8), .IN_READY(ir8), .A(a8), .B(b8),
        .OUT_VALID(ov8), .OUT_READY(ordy8), .Q(q8), .R(r8), .DZ(dz8)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic set_model(input logic [AW-1:0] va, input logic [BW-1:0] vb);
        exp_dz = (vb == 0);
        exp_q  = (vb == 0) ? {AW{1'b1}} : va / AW'(vb);
        exp_r  = (vb == 0) ? va[BW-1:0] : BW'(va % AW'(vb));
    endtask

    // Any cycle the result is offered it must match the model.
    always @(negedge clk) begin
        if (ov) begin
            check("cmp_q", q, exp_q);
            check("cmp_r", r, exp_r);
            check("cmp_dz", dz, exp_dz);
        end
    end

    task automatic do_op(input logic [AW-1:0] va, input logic [BW-1:0] vb, input int hold, input bit poke);
        int n;
        @(negedge clk);
        check("in_ready_idle", ir, 1);
        a = va; b = vb; iv = 1'b1;
        set_model(va, vb);
        @(negedge clk);
        iv = 1'b0;
        check("in_ready_after_accept", ir, 0);
        n = 0;
        while (!ov && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, (vb == 0) ? 0 : AW);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin a = 99; b = 3; iv = 1'b1; end
            @(negedge clk);
            check("bp_in_ready", ir, 0);
            check("bp_out_valid", ov, 1);
        end
        iv = 1'b0; ordy = 1'b1;
        @(negedge clk);
        ordy = 1'b0;
        check("post_in_ready", ir, 1);
        check("post_out_valid", ov, 0);
        check("post_hold_q", q, exp_q);
        check("post_hold_r", r, exp_r);
    endtask

    initial begin
        int n;
        logic [AW-1:0] va;
        logic [BW-1:0] vb;
        rst = 1'b1; iv = 1'b0; ordy = 1'b0; a = '0; b = '0;
        iv8 = 1'b0; ordy8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", ir, 1);
        check("rst_out_valid", ov, 0);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dz", dz, 0);
        check("rst_in_ready8", ir8, 1);
        rst = 1'b0;

        do_op(16'd1000, 8'd7, 0, 0);
        check("basic_q", q, 142); check("basic_r", r, 6); check("basic_dz", dz, 0);
        do_op(16'hFFFF, 8'hFF, 0, 0);
        check("ext1_q", q, 16'h0101); check("ext1_r", r, 0);
        do_op(16'hFFFF, 8'd1, 0, 0);
        check("ext2_q", q, 16'hFFFF); check("ext2_r", r, 0);
        do_op(16'd5, 8'd9, 0, 0);
        check("ext3_q", q, 0); check("ext3_r", r, 5);
        do_op(16'h1234, 8'd0, 0, 0);
        check("dz_q", q, 16'hFFFF); check("dz_r", r, 8'h34); check("dz_dz", dz, 1);
        do_op(16'd20, 8'd3, 0, 0);
        check("after_dz_q", q, 6); check("after_dz_r", r, 2); check("after_dz_dz", dz, 0);
        do_op(16'd1000, 8'd7, 5, 1);
        check("bp_q", q, 142); check("bp_r", r, 6);
        do_op(16'd99, 8'd3, 0, 0);
        check("bp_next_q", q, 33); check("bp_next_r", r, 0);

        @(negedge clk);
        a = 16'd1000; b = 8'd7; iv = 1'b1;
        set_model(16'd1000, 8'd7);
        @(negedge clk);
        iv = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", ir, 1);
        check("abort_out_valid", ov, 0);
        check("abort_q", q, 0);
        check("abort_r", r, 0);
        check("abort_dz", dz, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("abort_no_valid", ov, 0);
        end
        do_op(16'd50, 8'd6, 0, 0);
        check("post_abort_q", q, 8); check("post_abort_r", r, 2);

        @(negedge clk);
        a8 = 8'd200; b8 = 8'd13; iv8 = 1'b1;
        @(negedge clk);
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("w8_latency", n, 8);
        check("w8_q", q8, 15); check("w8_r", r8, 5); check("w8_dz", dz8, 0);
        ordy8 = 1'b1;
        @(negedge clk);
        ordy8 = 1'b0;
        check("w8_in_ready", ir8, 1);

        for (int i = 0; i < 1000; i++) begin
            va = AW'($urandom);
            vb = (i % 50 == 7) ? '0 : BW'($urandom);
            do_op(va, vb, i % 3, 0);
            if (vb != 0)
                check("rand_identity", (32'(q) * 32'(vb) + 32'(r) == 32'(va)) && (r < vb), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_inv_div_seq.md
Name: mult_inv_div_seq

Overview:
- Iterative unsigned divider; the inverse-direction companion to the registered-multiplier DSP test designs in the qlf_k6n10f flow.
- Computes Q = A / B and R = A % B, one quotient bit per clock (restoring algorithm).
- Input operands and outputs are registered so the dsp-ff inference passes see FF boundaries on both sides.
- valid/ready handshake on input and output. One operation in flight at a time.

Parameters:
- A_WIDTH, 16, dividend and quotient width; legal range 2..32.
- B_WIDTH, 8, divisor and remainder width; legal range 2..A_WIDTH.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous reset, active-high
- IN_VALID  input  1  operands present on A/B
- IN_READY  output  1  block accepts operands; high only in IDLE
- A  input  A_WIDTH  dividend
- B  input  B_WIDTH  divisor
- OUT_VALID  output  1  Q/R/DZ hold a result
- OUT_READY  input  1  consumer takes the result
- Q  output  A_WIDTH  quotient
- R  output  B_WIDTH  remainder
- DZ  output  1  divide-by-zero flag for the current result

Behaviour:
- Reset:
  - RST sampled high at a CLK edge forces state IDLE.
  - Outputs after that edge: IN_READY=1, OUT_VALID=0, Q=0, R=0, DZ=0.
  - Operand registers and iteration counter clear to 0.
  - IN_VALID is ignored on any edge where RST=1.
- States: IDLE, BUSY, DONE. IN_READY = (state==IDLE); OUT_VALID = (state==DONE). Both come straight from the state register, with no combinational path from the inputs.
- IDLE:
  - On an edge with IN_VALID=1, latch A and B into operand registers (this is the input register stage).
  - If B!=0: go to BUSY, clear the partial remainder (B_WIDTH+1 bits), load the dividend shift register with A, and set the counter to A_WIDTH.
  - If B==0: go directly to DONE with Q = all ones, R = A[B_WIDTH-1:0], DZ=1.
- BUSY:
  - Each edge, shift the next dividend MSB into the partial remainder.
  - If partial remainder >= B: subtract B and shift in a quotient bit of 1; otherwise shift in 0.
  - Decrement the counter.
  - The edge on which the counter goes from 1 to 0 loads Q, R and DZ=0, then goes to DONE.
  - IN_VALID is ignored in BUSY.
- Latency:
  - Acceptance edge = edge 0.
  - Normal case: OUT_VALID is first high after edge A_WIDTH (16 by default).
  - DZ case: OUT_VALID is first high after edge 0.
- DONE:
  - Q, R and DZ are stable while OUT_VALID=1.
  - On an edge with OUT_READY=1, return to IDLE.
  - Q, R and DZ keep their last values after the transfer. They change only when DONE is next entered.
  - OUT_READY is ignored outside DONE.
- No overlap: a new operand is accepted no earlier than the edge after the output transfer, because IN_READY rises in IDLE. Maximum throughput is one result per A_WIDTH+2 cycles.
- Reset mid-operation: RST in BUSY or DONE aborts the operation. No OUT_VALID pulse occurs for the aborted operation, and all outputs take their reset values.
- Arithmetic:
  - Fully unsigned.
  - Result satisfies Q*B + R == A with R < B for every B != 0.
  - A < B gives Q=0, R=A.
  - No overflow is possible for B != 0.

Test Plan:
- Basic, defaults: A=1000, B=7, IN_VALID one cycle. Required: IN_READY drops the next cycle, OUT_VALID rises exactly 16 edges after acceptance, Q=142, R=6, DZ=0.
- Extremes: A=16'hFFFF, B=8'hFF gives Q=16'h0101, R=0. Then A=16'hFFFF, B=1 gives Q=16'hFFFF, R=0. Then A=5, B=9 gives Q=0, R=5.
- Divide by zero: A=16'h1234, B=0. Required: OUT_VALID high after acceptance edge 0, Q=16'hFFFF, R=8'h34, DZ=1. Next operation 20/3 gives Q=6, R=2, DZ=0.
- Backpressure:
  - Hold OUT_READY=0 for 5 cycles after OUT_VALID rises. Q/R must stay stable, IN_READY must stay 0, and IN_VALID pulses carrying A=99, B=3 must be ignored.
  - Raise OUT_READY; IN_READY=1 must appear the next cycle.
  - Then 99/3 gives Q=33, R=0.
- Reset mid-BUSY: start 1000/7, assert RST on the 5th edge after acceptance. Required: OUT_VALID never pulses, Q=R=DZ=0, IN_READY=1. Then 50/6 gives Q=8, R=2 with full 16-cycle latency.
- Parameter sweep: A_WIDTH=8, B_WIDTH=8, 200/13 gives Q=15, R=5 at 8-cycle latency. Random 1000-vector check of Q*B+R==A with R<B for B!=0.
